// File: rtl/ring_stop.sv
// Per-core ring stop: registers the ring slot, arbitrates the token for the local messenger,
// strips returning own messages. Optional token watchdog: define RING_TOKEN_WATCHDOG_EN.
module ring_stop #(
  parameter int unsigned TOKEN_MASTER = 0,
  parameter int unsigned WDOG_CYCLES  = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic [31:0] msgrRingOut,
  input  logic [3:0]  msgrSlotTypeOut,
  input  logic [3:0]  msgrSourceOut,
  input  logic        msgrDriveRing,
  input  logic        msgrWantsToken,
  output logic        msgrAcquireToken,
  output logic        tokenHeld,
  output logic        protocolError
);

  localparam logic [3:0] SlotToken = 4'd1;
  localparam logic [3:0] SlotNull  = 4'd7;
  localparam logic [3:0] SlotMsg   = 4'd8;

  typedef enum logic [1:0] {StIdle, StHold, StInject} state_e;

  localparam state_e ResetState = (TOKEN_MASTER != 0) ? StInject : StIdle;

  state_e      r_state, w_state_d;
  logic [31:0] r_ring, w_ring_d;
  logic [3:0]  r_type, w_type_d;
  logic [3:0]  r_src, w_src_d;
  logic        r_err, w_err_set;
  logic        w_token_in, w_own_msg, w_grant, w_wdog_fire;

  assign w_token_in = (SlotTypeIn == SlotToken);
  assign w_own_msg  = (SlotTypeIn == SlotMsg) && (SourceIn == whichCore);
  // Combinational so the messenger can drive its header in the grant cycle.
  assign w_grant    = (r_state == StIdle) && w_token_in && msgrWantsToken;

`ifdef RING_TOKEN_WATCHDOG_EN
  logic [12:0] r_wdog, w_wdog_d;

  always_comb begin
    w_wdog_d    = '0;
    w_wdog_fire = 1'b0;
    if ((TOKEN_MASTER != 0) && (r_state == StIdle) && !w_token_in) begin
      if (r_wdog == 13'(WDOG_CYCLES - 1)) begin
        w_wdog_fire = 1'b1;
      end else begin
        w_wdog_d = r_wdog + 13'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= w_wdog_d;
    end
  end
`else
  logic [12:0] w_unused_wdog;
  assign w_unused_wdog = 13'(WDOG_CYCLES);
  assign w_wdog_fire   = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_ring_d  = RingIn;
    w_type_d  = SlotTypeIn;
    w_src_d   = SourceIn;
    w_err_set = 1'b0;
    unique case (r_state)
      StInject: begin
        w_ring_d  = '0;
        w_type_d  = SlotToken;
        w_src_d   = whichCore;
        w_state_d = StIdle;
      end
      StIdle: begin
        if (w_grant) begin
          w_ring_d  = msgrRingOut;
          w_type_d  = msgrSlotTypeOut;
          w_src_d   = msgrSourceOut;
          w_state_d = StHold;
        end else begin
          if (w_own_msg) begin
            w_ring_d = '0;
            w_type_d = SlotNull;
            w_src_d  = '0;
          end
          if (msgrDriveRing) begin
            w_err_set = 1'b1;
          end
          if (w_wdog_fire) begin
            w_state_d = StInject;
          end
        end
      end
      StHold: begin
        // Incoming slots are never forwarded while the ring is ours.
        if (w_token_in || ((SlotTypeIn == SlotMsg) && !w_own_msg)) begin
          w_err_set = 1'b1;
        end
        if (msgrDriveRing) begin
          w_ring_d = msgrRingOut;
          w_type_d = msgrSlotTypeOut;
          w_src_d  = msgrSourceOut;
        end else begin
          w_ring_d  = '0;
          w_type_d  = SlotToken;
          w_src_d   = whichCore;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ResetState;
      r_ring  <= '0;
      r_type  <= SlotNull;
      r_src   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ring  <= w_ring_d;
      r_type  <= w_type_d;
      r_src   <= w_src_d;
      r_err   <= r_err | w_err_set;
    end
  end

  assign RingOut          = r_ring;
  assign SlotTypeOut      = r_type;
  assign SourceOut        = r_src;
  assign msgrAcquireToken = w_grant;
  assign tokenHeld        = (r_state == StHold);
  assign protocolError    = r_err;

endmodule
